multi_clk_div: RTL and testbench

MULTI_CLK_DIV -- requirements
Module: multi_clk_div

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_channel.sv | 73 +++++++
 rtl/multi_clk_div.sv | 59 +++++
 tb/tb_multi_clk_div.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int          CNT_W_DEF       = 24;
  localparam int unsigned DEFAULT_DIV_DEF = 500_000;

  // Channel-select width; a single channel still gets a 1-bit select port.
  function automatic int ch_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: pending/active divisor, up-counter, tick pulse and
// square-wave output, all registered on clk_i.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             sync_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic [CNT_W-1:0] div_o
);

  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] a_q, a_d;
  logic [CNT_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] a_m1;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;

  assign a_m1 = a_q - CNT_W'(1);

  always_comb begin
    p_d    = we_i ? div_i : p_q;
    a_d    = a_q;
    c_d    = c_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    if (sync_i) begin
      c_d   = '0;
      clk_d = 1'b0;
      a_d   = p_q;
    end else if (!en_i || (a_q == '0)) begin
      // A stopped channel has no period to protect, so it follows P directly.
      c_d = '0;
      a_d = p_q;
    end else if (c_q == a_m1) begin
      c_d    = '0;
      tick_d = 1'b1;
      clk_d  = ~clk_q;
      a_d    = p_q;
    end else begin
      c_d = c_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q    <= RST_DIV;
      a_q    <= RST_DIV;
      c_q    <= '0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      a_q    <= a_d;
      c_q    <= c_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_q;
  assign div_o     = a_q;

endmodule

// File: rtl/multi_clk_div.sv
// N_CH independent clock-enable dividers with per-channel divisor writes,
// a shared phase-align strobe and active-divisor read-back.
module multi_clk_div
  import clk_div_pkg::*;
#(
  parameter int          N_CH        = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic [N_CH-1:0]               en,
  input  logic                          cfg_we,
  input  logic [ch_sel_w(N_CH)-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  input  logic                          sync,
  output logic [N_CH-1:0]               tick,
  output logic [N_CH-1:0]               clk_out,
  output logic [CNT_W-1:0]              div_rd
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] div_act [N_CH];
  logic [N_CH-1:0]  we_ch;

  // Out-of-range selects match no channel, so such writes are dropped.
  always_comb begin
    we_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && (int'(cfg_ch) == i)) we_ch[i] = 1'b1;
    end
  end

  always_comb begin
    div_rd = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(cfg_ch) == i) div_rd = div_act[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk_i     (clk_in),
      .rst_ni    (rst_n),
      .en_i      (en[g]),
      .we_i      (we_ch[g]),
      .div_i     (cfg_div),
      .sync_i    (sync),
      .tick_o    (tick[g]),
      .clk_out_o (clk_out[g]),
      .div_o     (div_act[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div: 3 channels, short reset divisor.
module tb_multi_clk_div;

  localparam int N_CH  = 3;
  localparam int CNT_W = 16;
  localparam int DEF   = 20;

  logic              clk_in;
  logic              rst_n;
  logic [N_CH-1:0]   en;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              sync;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   clk_out;
  logic [CNT_W-1:0]  div_rd;

  multi_clk_div #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .sync    (sync),
    .tick    (tick),
    .clk_out (clk_out),
    .div_rd  (div_rd)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [2:0]  tick;
    logic [2:0]  clk;
    logic        chk_rd;
    logic [15:0] rd;
  } exp_t;

  typedef struct {
    logic [2:0]  en;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] div;
    logic        sync;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(string n, logic [2:0] t, logic [2:0] c, logic rc, logic [15:0] r);
    exp_t x;
    x.name = n; x.tick = t; x.clk = c; x.chk_rd = rc; x.rd = r;
    return x;
  endfunction

  function automatic vec_t mv(logic [2:0] e, logic w, logic [1:0] c, logic [15:0] d, exp_t x);
    vec_t v;
    v.en = e; v.we = w; v.ch = c; v.div = d; v.sync = 1'b0; v.e = x;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask

  task automatic compare_next();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
    end else begin
      x = sb.pop_front();
      chk({x.name, "_tick"}, {29'd0, tick}, {29'd0, x.tick});
      chk({x.name, "_clk"}, {29'd0, clk_out}, {29'd0, x.clk});
      if (x.chk_rd) chk({x.name, "_rd"}, {16'd0, div_rd}, {16'd0, x.rd});
    end
  endtask

  task automatic step(input logic [2:0] en_v, input logic we_v, input logic [1:0] ch_v,
                      input logic [15:0] div_v, input logic sync_v, input exp_t e);
    @(negedge clk_in);
    en = en_v; cfg_we = we_v; cfg_ch = ch_v; cfg_div = div_v; sync = sync_v;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    compare_next();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic t0, t1, c0, c1;

    rst_n = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tick", {29'd0, tick}, 32'd0);
    chk("rst_clk", {29'd0, clk_out}, 32'd0);
    chk("rst_rd", {16'd0, div_rd}, DEF);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Channel 0 at divisor 4: tick every 4th edge, clk_out period 8.
    step(3'b000, 1'b1, 2'd0, 16'd4, 1'b0, mk("t1_wr", 3'b000, 3'b000, 1'b1, 16'(DEF)));
    step(3'b000, 1'b0, 2'd0, 16'd0, 1'b0, mk("t1_ld", 3'b000, 3'b000, 1'b1, 16'd4));
    for (int k = 1; k <= 14; k++) begin
      t0 = (k % 4 == 0);
      c0 = ((k / 4) % 2) != 0;
      step(3'b001, 1'b0, 2'd0, 16'd0, 1'b0, mk("t1_run", {2'b00, t0}, {2'b00, c0}, 1'b1, 16'd4));
    end
    repeat (2) step(3'b000, 1'b0, 2'd0, 16'd0, 1'b0, mk("t1_hold", 3'b000, 3'b001, 1'b1, 16'd4));

    // Channel 1 at 10, rewritten to 3 mid-period.
    step(3'b000, 1'b1, 2'd1, 16'd10, 1'b0, mk("t2_wr", 3'b000, 3'b001, 1'b1, 16'(DEF)));
    step(3'b000, 1'b0, 2'd1, 16'd0, 1'b0, mk("t2_ld", 3'b000, 3'b001, 1'b1, 16'd10));
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      t1 = (k == 10) || (k == 13) || (k == 16) || (k == 19);
      if (t1) n++;
      c1 = (n % 2) != 0;
      step(3'b010, (k == 6), 2'd1, 16'd3, 1'b0,
           mk("t2_run", {1'b0, t1, 1'b0}, {1'b0, c1, 1'b1}, 1'b1, (k >= 10) ? 16'd3 : 16'd10));
    end
    step(3'b000, 1'b0, 2'd1, 16'd0, 1'b0, mk("t2_off", 3'b000, 3'b001, 1'b1, 16'd3));

    // Divisor 1 and 0 on channel 2, then a write to a non-existent channel.
    tbl.push_back(mv(3'b000, 1'b1, 2'd2, 16'd1, mk("t3_wr1",  3'b000, 3'b001, 1'b1, 16'(DEF))));
    tbl.push_back(mv(3'b000, 1'b0, 2'd2, 16'd0, mk("t3_ld1",  3'b000, 3'b001, 1'b1, 16'd1)));
    tbl.push_back(mv(3'b100, 1'b0, 2'd2, 16'd0, mk("t3_a1",   3'b100, 3'b101, 1'b1, 16'd1)));
    tbl.push_back(mv(3'b100, 1'b0, 2'd2, 16'd0, mk("t3_a1",   3'b100, 3'b001, 1'b1, 16'd1)));
    tbl.push_back(mv(3'b100, 1'b0, 2'd2, 16'd0, mk("t3_a1",   3'b100, 3'b101, 1'b1, 16'd1)));
    tbl.push_back(mv(3'b100, 1'b1, 2'd2, 16'd0, mk("t3_wr0",  3'b100, 3'b001, 1'b1, 16'd1)));
    tbl.push_back(mv(3'b100, 1'b0, 2'd2, 16'd0, mk("t3_tc0",  3'b100, 3'b101, 1'b1, 16'd0)));
    tbl.push_back(mv(3'b100, 1'b0, 2'd2, 16'd0, mk("t3_a0",   3'b000, 3'b101, 1'b1, 16'd0)));
    tbl.push_back(mv(3'b100, 1'b0, 2'd2, 16'd0, mk("t3_a0",   3'b000, 3'b101, 1'b1, 16'd0)));
    tbl.push_back(mv(3'b100, 1'b0, 2'd2, 16'd0, mk("t3_a0",   3'b000, 3'b101, 1'b1, 16'd0)));
    tbl.push_back(mv(3'b000, 1'b1, 2'd3, 16'd7, mk("t4_bad",  3'b000, 3'b101, 1'b0, 16'd0)));
    tbl.push_back(mv(3'b000, 1'b0, 2'd0, 16'd0, mk("t4_rd0",  3'b000, 3'b101, 1'b1, 16'd4)));
    tbl.push_back(mv(3'b000, 1'b0, 2'd1, 16'd0, mk("t4_rd1",  3'b000, 3'b101, 1'b1, 16'd3)));
    tbl.push_back(mv(3'b000, 1'b0, 2'd2, 16'd0, mk("t4_rd2",  3'b000, 3'b101, 1'b1, 16'd0)));
    foreach (tbl[i]) step(tbl[i].en, tbl[i].we, tbl[i].ch, tbl[i].div, tbl[i].sync, tbl[i].e);

    // Channels at 3 and 5, sync landing on channel 0's terminal count.
    step(3'b000, 1'b1, 2'd0, 16'd3, 1'b0, mk("t5_wr0", 3'b000, 3'b101, 1'b1, 16'd4));
    step(3'b000, 1'b1, 2'd1, 16'd5, 1'b0, mk("t5_wr1", 3'b000, 3'b101, 1'b1, 16'd3));
    step(3'b000, 1'b0, 2'd1, 16'd0, 1'b0, mk("t5_ld",  3'b000, 3'b101, 1'b1, 16'd5));
    for (int k = 1; k <= 8; k++) begin
      t0 = (k % 3 == 0); t1 = (k % 5 == 0);
      c0 = 1'b1 ^ (((k / 3) % 2) != 0);
      c1 = ((k / 5) % 2) != 0;
      step(3'b011, 1'b0, 2'd1, 16'd0, 1'b0, mk("t5_pre", {1'b0, t1, t0}, {1'b1, c1, c0}, 1'b1, 16'd5));
    end
    step(3'b011, 1'b0, 2'd1, 16'd0, 1'b1, mk("t5_sync", 3'b000, 3'b000, 1'b1, 16'd5));
    for (int j = 1; j <= 6; j++) begin
      t0 = (j % 3 == 0); t1 = (j % 5 == 0);
      c0 = ((j / 3) % 2) != 0;
      c1 = ((j / 5) % 2) != 0;
      step(3'b011, 1'b0, 2'd1, 16'd0, 1'b0, mk("t5_post", {1'b0, t1, t0}, {1'b0, c1, c0}, 1'b1, 16'd5));
    end
    step(3'b000, 1'b0, 2'd1, 16'd0, 1'b0, mk("t5_off", 3'b000, 3'b010, 1'b1, 16'd5));

    // Reset in mid-period, then the first tick comes from the reset divisor.
    step(3'b000, 1'b1, 2'd0, 16'd12, 1'b0, mk("t6_wr0", 3'b000, 3'b010, 1'b1, 16'd3));
    step(3'b000, 1'b1, 2'd2, 16'd1,  1'b0, mk("t6_wr2", 3'b000, 3'b010, 1'b1, 16'd0));
    step(3'b000, 1'b0, 2'd0, 16'd0,  1'b0, mk("t6_ld",  3'b000, 3'b010, 1'b1, 16'd12));
    for (int k = 1; k <= 7; k++) begin
      c1 = (k % 2) != 0;
      step(3'b101, 1'b0, 2'd0, 16'd0, 1'b0, mk("t6_run", 3'b100, {c1, 1'b1, 1'b0}, 1'b1, 16'd12));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tick", {29'd0, tick}, 32'd0);
    chk("t6_rst_clk", {29'd0, clk_out}, 32'd0);
    chk("t6_rst_rd", {16'd0, div_rd}, DEF);
    rst_n = 1'b1;
    for (int k = 1; k <= DEF; k++) begin
      step(3'b101, 1'b0, 2'd0, 16'd0, 1'b0,
           mk("t6_after", (k == DEF) ? 3'b101 : 3'b000, (k == DEF) ? 3'b101 : 3'b000, 1'b1, 16'(DEF)));
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
